// File: rtl/fifo_sseg_disp.sv
// -----------------------------------------------------------------------------
// fifo_sseg_disp
//
// Drains a first-word-fall-through FIFO one word at a time at a slow, fixed
// pace and shows the last two consumed bytes on a 4-digit multiplexed
// seven-segment display. The display is hex, with the most recent byte on
// the two right-hand digits. The decimal point of digit 0 is lit while the
// FIFO is empty.
//
// Parameters
//   D_WIDTH  FIFO word width (fixed at 8)
//   PACE     HOLD cycles after each pop (>= 1); pop-to-pop spacing is PACE+2
//   REF_W    display refresh counter width (>= 3); top two bits pick the digit
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   empty     in   upstream FIFO empty flag
//   r_data    in   upstream FIFO head word (valid whenever empty=0)
//   rd        out  FIFO pop strobe, high for exactly one cycle per word
//   an        out  digit anode enables, active-low, exactly one low
//   sseg      out  {dp,g,f,e,d,c,b,a}, active-low
//   byte_cnt  out  words consumed since reset, modulo 256
//   state_o   out  FSM state for observation (0=IDLE, 1=POP, 2=HOLD)
//
// Handshake: the FIFO presents a word whenever empty=0. A word is consumed
// on the rising edge that ends a cycle in which rd=1; the FIFO must advance
// its head on that same edge.
// -----------------------------------------------------------------------------
module fifo_sseg_disp #(
  parameter int D_WIDTH = 8,
  parameter int PACE    = 2_000_000,
  parameter int REF_W   = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               empty,
  input  logic [D_WIDTH-1:0] r_data,
  output logic               rd,
  output logic [3:0]         an,
  output logic [7:0]         sseg,
  output logic [7:0]         byte_cnt,
  output logic [1:0]         state_o
);

  // Pace counter only needs to reach PACE-1.
  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [PW-1:0] PACE_LAST = PW'(PACE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      pace_q, pace_d;
  logic [15:0]        disp_q, disp_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [REF_W-1:0]   ref_q;

  logic [1:0]         sel;
  logic [3:0]         nib;
  logic [6:0]         seg7;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pace_q  <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      pace_q  <= pace_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pace_d  = pace_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = POP;
      end
      POP: begin
        // A POP that finds the FIFO empty still burns a full HOLD period,
        // so a misbehaving source cannot speed up the pace.
        pace_d  = '0;
        state_d = HOLD;
        if (!empty) begin
          disp_d = {disp_q[7:0], r_data[7:0]};
          cnt_d  = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        pace_d = pace_q + 1'b1;
        if (pace_q == PACE_LAST) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded straight from the state register; reset forces IDLE, which
  // drops rd asynchronously.
  assign rd       = (state_q == POP) && !empty;
  assign byte_cnt = cnt_q;
  assign state_o  = state_q;

  // ---------------------------------------------------------------------------
  // Display multiplexing
  // ---------------------------------------------------------------------------
  assign sel = ref_q[REF_W-1 -: 2];

  always_comb begin
    an  = 4'b1110;
    nib = disp_q[3:0];
    case (sel)
      2'd0: begin an = 4'b1110; nib = disp_q[3:0];   end
      2'd1: begin an = 4'b1101; nib = disp_q[7:4];   end
      2'd2: begin an = 4'b1011; nib = disp_q[11:8];  end
      2'd3: begin an = 4'b0111; nib = disp_q[15:12]; end
      default: begin an = 4'b1110; nib = disp_q[3:0]; end
    endcase
  end

  always_comb begin
    seg7 = 7'h7F;
    case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  end

  // Decimal point on digit 0 flags an empty FIFO.
  assign sseg = {~((sel == 2'd0) && empty), seg7};

endmodule

// File: tb/tb_fifo_sseg_disp.sv
// -----------------------------------------------------------------------------
// tb_fifo_sseg_disp
//
// Bench for fifo_sseg_disp with PACE=2, REF_W=4. The bench plays the upstream
// FWFT FIFO from a queue. Every word it offers is also pushed onto an expected
// queue; a monitor running on the falling edge pops that queue whenever the
// DUT consumed a word and keeps a reference picture of the display contents,
// the consumed-word count and the refresh phase. Every falling edge the DUT's
// anodes, segments and count are compared with that picture.
// -----------------------------------------------------------------------------
module tb_fifo_sseg_disp;

  localparam int PACE  = 2;
  localparam int REF_W = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [7:0] byte_cnt;
  logic [1:0] state_o;

  fifo_sseg_disp #(
    .D_WIDTH (8),
    .PACE    (PACE),
    .REF_W   (REF_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .empty    (empty),
    .r_data   (r_data),
    .rd       (rd),
    .an       (an),
    .sseg     (sseg),
    .byte_cnt (byte_cnt),
    .state_o  (state_o)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];   // upstream FIFO contents
  logic [7:0] exp_q[$];    // words expected to be consumed, in order

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] m_disp = 16'h0000;   // last two consumed bytes
  int          m_cnt = 0;           // words consumed since reset
  int          pops = 0;            // total pops seen by the monitor
  int          cyc = 0;             // rising edges since time 0
  int          since_rst = 0;       // rising edges since reset released
  logic        pop_edge = 1'b0;     // DUT consumed a word on the last rising edge
  int          pop_cyc = 0;
  int          last_pop_cyc = 0;
  logic        gap_ok = 1'b0;       // next pop should follow at minimum spacing

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void fifo_outs();
    empty  = (fifo_q.size() == 0);
    r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_outs();
  endtask

  // ---------------------------------------------------------------------------
  // Rising-edge bookkeeping: did a pop happen, and how far into the refresh
  // cycle we are.
  // ---------------------------------------------------------------------------
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      since_rst = 0;
      pop_edge  = 1'b0;
      if (clk) cyc++;
    end else begin
      pop_edge  = rd;
      if (rd) pop_cyc = cyc;
      since_rst++;
      cyc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial forever begin
    int         sel;
    logic [3:0] nib;
    logic [7:0] w;
    logic       popped;
    @(negedge clk);
    popped = 1'b0;
    if (!reset_n) begin
      m_disp = 16'h0000;
      m_cnt  = 0;
      gap_ok = 1'b0;
    end else if (pop_edge) begin
      popped = 1'b1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: rd consumed a word, expected none pending");
      end else begin
        w = exp_q.pop_front();
        m_disp = {m_disp[7:0], w};
        m_cnt++;
        pops++;
        if (gap_ok) chk("pop_spacing", pop_cyc - last_pop_cyc, PACE + 2);
        last_pop_cyc = pop_cyc;
      end
      chk("rd_one_cycle", {31'd0, rd}, 0);
    end
    if (rd && empty) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_while_empty: rd=1 with empty=1");
    end

    sel = (since_rst % 16) / 4;
    nib = 4'((m_disp >> (4 * sel)) & 16'h000F);
    chk("an", {28'd0, an}, {28'd0, ~(4'b0001 << sel)});
    chk("sseg", {24'd0, sseg}, {24'd0, ~((sel == 0) && empty), seg_tab[nib]});
    chk("byte_cnt", {24'd0, byte_cnt}, m_cnt % 256);

    // Upstream FIFO advances its head only after the display check, since
    // the decimal point follows empty combinationally.
    if (popped) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      gap_ok = (fifo_q.size() != 0);
      fifo_outs();
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("drain_done", exp_q.size(), 0);
    repeat (PACE + 3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cnt_an [4];
    int p0;
    int n_rd;
    int found;

    // Reset held with an empty FIFO.
    @(negedge clk);
    #1;
    chk("rst_rd", {31'd0, rd}, 0);
    chk("rst_an", {28'd0, an}, 32'hE);
    chk("rst_sseg", {24'd0, sseg}, 32'h40);
    chk("rst_byte_cnt", {24'd0, byte_cnt}, 0);
    chk("rst_state", {30'd0, state_o}, 0);
    #1 reset_n = 1'b1;

    // Two pops: 0x04 then 0x03.
    @(negedge clk);
    #2 push(8'h04);
    push(8'h03);
    p0 = pops;
    drain(50);
    #1;
    chk("two_pops_count", pops - p0, 2);
    chk("two_pops_byte_cnt", {24'd0, byte_cnt}, 2);
    chk("two_pops_idle", {30'd0, state_o}, 0);

    // FIFO empty for 100 cycles: nothing moves.
    n_rd = 0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (rd) n_rd++;
    end
    chk("empty_no_rd", n_rd, 0);
    chk("empty_byte_cnt", {24'd0, byte_cnt}, m_cnt);

    // Refresh scan of 0x1234.
    do_reset();
    @(negedge clk);
    #2 push(8'h12);
    push(8'h34);
    drain(50);
    for (int k = 0; k < 4; k++) cnt_an[k] = 0;
    repeat (16) begin
      @(negedge clk);
      #1;
      case (an)
        4'b1110: begin cnt_an[0]++; chk("scan_d0", {25'd0, sseg[6:0]}, 32'h19); end
        4'b1101: begin cnt_an[1]++; chk("scan_d1", {25'd0, sseg[6:0]}, 32'h30); end
        4'b1011: begin cnt_an[2]++; chk("scan_d2", {25'd0, sseg[6:0]}, 32'h24); end
        4'b0111: begin cnt_an[3]++; chk("scan_d3", {25'd0, sseg[6:0]}, 32'h79); end
        default: chk("scan_an_onehot", {28'd0, an}, 32'hE);
      endcase
    end
    for (int k = 0; k < 4; k++) chk("scan_dwell", cnt_an[k], 4);

    // Reset pulsed during the second POP cycle.
    do_reset();
    @(negedge clk);
    #2 push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    p0 = pops;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      #1;
      if (rd && (pops - p0) == 1) found = 1;
    end
    chk("midpop_found", found, 1);
    reset_n = 1'b0;
    #1;
    chk("midpop_rd_drop", {31'd0, rd}, 0);
    chk("midpop_byte_cnt", {24'd0, byte_cnt}, 0);
    chk("midpop_state", {30'd0, state_o}, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midpop_resume_rd", {31'd0, rd}, 1);
    drain(50);
    chk("midpop_total_pops", pops - p0, 3);
    chk("midpop_final_cnt", {24'd0, byte_cnt}, 2);

    // Random bursts with random gaps.
    repeat (20) begin
      @(negedge clk);
      #2;
      repeat ($urandom_range(1, 3)) push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain(400);

    // 257 words streamed: count wraps to 1.
    do_reset();
    @(negedge clk);
    #2;
    repeat (257) push(8'($urandom));
    p0 = pops;
    drain(257 * (PACE + 2) + 100);
    #1;
    chk("wrap_pops", pops - p0, 257);
    chk("wrap_byte_cnt", {24'd0, byte_cnt}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sseg_disp.md
FIFO_SSEG_DISP -- requirements
Module: fifo_sseg_disp

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: width of the FIFO read-data word; fixed at 8 for this block.
REQ-002 SHALL have parameter PACE, default 2_000_000: number of HOLD cycles after each pop (minimum 1).
REQ-003 SHALL have parameter REF_W, default 18: width of the display refresh counter (minimum 3).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port empty  input  1: FIFO empty flag from the upstream FIFO.
REQ-007 SHALL have port r_data  input  D_WIDTH: FIFO head word, first-word-fall-through (valid whenever empty=0).
REQ-008 SHALL have port rd  output  1: FIFO pop strobe, one clk cycle per consumed word.
REQ-009 SHALL have port an  output  4: digit anode enables, active-low.
REQ-010 SHALL have port sseg  output  8: {dp,g,f,e,d,c,b,a}, all active-low.
REQ-011 SHALL have port byte_cnt  output  8: number of words consumed since reset, modulo 256.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, POP, HOLD.
REQ-013 IDLE: SHALL go to POP when empty=0 is sampled; otherwise stay in IDLE.
REQ-014 POP: SHALL last exactly one cycle; rd = (state==POP) & ~empty, decoded from the state register with no extra latency.
REQ-015 POP with empty=0: on the same rising edge, disp_reg[15:0] <= {disp_reg[7:0], r_data} and byte_cnt increments.
REQ-016 POP with empty=1 (protocol violation): rd=0, no shift, no count; next state is still HOLD.
REQ-017 POP SHALL clear pace_cnt and go to HOLD.
REQ-018 HOLD: pace_cnt increments each cycle; after PACE HOLD cycles, go to IDLE.
REQ-019 Resulting back-to-back pop spacing with FIFO non-empty SHALL be exactly PACE+2 cycles.
REQ-020 byte_cnt SHALL wrap from 255 to 0 without a flag.
REQ-021 ref_cnt (REF_W bits) SHALL increment every cycle and wrap freely; sel = ref_cnt[REF_W-1:REF_W-2].
REQ-022 Digit selection SHALL be: sel 0 -> an=1110, nibble disp_reg[3:0]; sel 1 -> an=1101, [7:4]; sel 2 -> an=1011, [11:8]; sel 3 -> an=0111, [15:12].
REQ-023 sseg[6:0] SHALL decode the selected nibble as hex, with the following values: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-024 sseg[7] (dp) SHALL be 0 (lit) only when sel=0 and empty=1; otherwise 1.
REQ-025 an and sseg SHALL be combinational from ref_cnt, disp_reg and empty; exactly one an bit SHALL be low at all times.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE, disp_reg=0x0000, pace_cnt=0, ref_cnt=0, byte_cnt=0.
REQ-027 During reset, outputs SHALL be rd=0, an=1110, sseg[6:0]=0x40, and sseg[7]=~empty.
REQ-028 Reset asserted during POP SHALL drop rd in the same instant, with no shift and no count.
REQ-029 After reset_n rises, the first pop SHALL occur no earlier than the second rising edge.

Verification (bench uses PACE=2, REF_W=4)
REQ-030 Reset test: reset_n=0 with empty=1 -> rd=0, an=1110, sseg=0x40 (dp lit), byte_cnt=0.
REQ-031 Two pops: FIFO holds 0x04 then 0x03 -> two 1-cycle rd pulses 4 cycles apart; disp_reg=0x0403, byte_cnt=2, and FSM then idles.
REQ-032 Empty hold: empty=1 for 100 cycles -> rd never asserted, disp_reg and byte_cnt unchanged.
REQ-033 Refresh: with disp_reg=0x1234 -> an steps 1110,1101,1011,0111 every 4 cycles, sseg[6:0] = 0x19, 0x30, 0x24, 0x79 respectively, then repeats.
REQ-034 Reset mid-operation: reset_n pulsed low during a POP cycle -> rd falls immediately, disp_reg=0x0000, byte_cnt=0, and the FSM resumes from IDLE.
REQ-035 Wrap: 257 words streamed -> 257 rd pulses, byte_cnt=1.
